// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter for a shared 4:1 mux, registered select/grant and data
//   clk, reset (sync, active-high); req[3:0] requests; i0..i3 data inputs
//   gnt one-hot grant; s1/s0 owner index; busy while granted; y/y_valid registered mux output
module rr_mux_arbiter #(
  parameter int DW = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    req,
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  input  logic [DW-1:0] i2,
  input  logic [DW-1:0] i3,
  output logic [3:0]    gnt,
  output logic          s1,
  output logic          s0,
  output logic          busy,
  output logic [DW-1:0] y,
  output logic          y_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_d;
  logic [1:0] last, last_d, win;
  logic [7:0] cnt, cnt_d;
  logic [3:0] cand;
  logic own_req, any, lim, go;
  logic [DW-1:0] sel_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last <= 2'd3;
      cnt <= '0;
      gnt <= '0;
      {s1, s0} <= 2'b00;
      busy <= 1'b0;
      y <= '0;
      y_valid <= 1'b0;
    end else begin
      state <= state_d;
      last <= last_d;
      cnt <= cnt_d;
      gnt <= state_d == GRANT ? 4'b0001 << last_d : 4'b0000;
      busy <= state_d == GRANT;
      if (go) {s1, s0} <= win;
      y_valid <= busy;
      if (busy) y <= sel_data;
    end
  end
  // in GRANT, last is the current owner; it is masked so a forced switch never re-picks it
  always_comb begin
    own_req = req[last];
    cand = state == GRANT ? req & ~(4'b0001 << last) : req;
    win = last;
    for (int k = 4; k >= 1; k--)
      if (cand[2'(last + 2'(k))]) win = 2'(last + 2'(k));
    any = |cand;
    lim = cnt == 8'(HOLD_MAX - 1);
    go = any && (state == IDLE || !own_req || lim);
    state_d = go || (state == GRANT && own_req) ? GRANT : IDLE;
    last_d = go ? win : last;
    cnt_d = go ? 8'd0 : (state == GRANT && own_req && !lim) ? cnt + 8'd1 : cnt;
  end
  always_comb sel_data = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed and randomized checks of rr_mux_arbiter against a behavioural model
module tb_rr_mux_arbiter;
  localparam int DW = 4;
  localparam int HM = 4;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req;
  logic [DW-1:0] i0, i1, i2, i3;
  logic [3:0] gnt;
  logic s1, s0, busy, y_valid;
  logic [DW-1:0] y;
  int n_chk = 0;
  int n_fail = 0;
  int m_busy, m_own, m_sel, m_last, m_cnt, m_y, m_yv;
  rr_mux_arbiter #(.DW(DW), .HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset), .req(req),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .gnt(gnt), .s1(s1), .s0(s0), .busy(busy), .y(y), .y_valid(y_valid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic rand_data();
    i0 = DW'($urandom);
    i1 = DW'($urandom);
    i2 = DW'($urandom);
    i3 = DW'($urandom);
  endtask
  // advance the model by one edge using the current inputs, then compare after the edge
  task automatic step();
    int d[4];
    int w;
    bit own_req;
    d = '{int'(i0), int'(i1), int'(i2), int'(i3)};
    if (reset) begin
      m_busy = 0; m_own = 0; m_sel = 0; m_last = 3; m_cnt = 0; m_y = 0; m_yv = 0;
    end else begin
      m_yv = m_busy;
      if (m_busy != 0) m_y = d[m_sel];
      w = -1;
      for (int k = 1; k <= 4; k++) begin
        int j;
        j = (m_last + k) % 4;
        if (w < 0 && req[j] && !(m_busy != 0 && j == m_own)) w = j;
      end
      own_req = m_busy != 0 && req[m_own];
      if (w >= 0 && (m_busy == 0 || !own_req || m_cnt == HM - 1)) begin
        m_busy = 1; m_own = w; m_sel = w; m_last = w; m_cnt = 0;
      end else if (m_busy != 0 && !own_req) m_busy = 0;
      else if (m_busy != 0 && m_cnt < HM - 1) m_cnt++;
    end
    @(posedge clk);
    #1;
    check("gnt", gnt, m_busy != 0 ? 32'(1 << m_own) : 0);
    check("sel", {s1, s0}, m_sel);
    check("busy", busy, m_busy);
    check("y", y, m_y);
    check("y_valid", y_valid, m_yv);
    check("onehot", $countones(gnt) <= 1, 1);
    check("gnt_sel", gnt[{s1, s0}], busy);
  endtask
  initial begin
    reset = 1'b1;
    req = 4'b0000;
    rand_data();
    step();
    step();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_yv", y_valid, 0);
    reset = 1'b0;
    req = 4'b0001;
    i0 = 4'h1;
    step();
    check("t1_gnt", gnt, 4'b0001);
    check("t1_busy", busy, 1);
    step();
    check("t1_y", y, 4'h1);
    check("t1_yv", y_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1111;
    for (int n = 1; n <= 20; n++) begin
      rand_data();
      step();
      check("t2_owner", {s1, s0}, ((n - 1) / 4) % 4);
      check("t2_busy", busy, 1);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b0100;
    for (int n = 0; n < 20; n++) begin
      rand_data();
      step();
      check("t3_hold", gnt, 4'b0100);
    end
    req = 4'b0110;
    step();
    check("t3_switch", gnt, 4'b0010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b0010;
    i1 = 4'ha;
    i3 = 4'h5;
    step();
    check("t4_own1", gnt, 4'b0010);
    req = 4'b1000;
    step();
    check("t4_gnt", gnt, 4'b1000);
    check("t4_sel", {s1, s0}, 2'b11);
    check("t4_y_i1", y, 4'ha);
    step();
    check("t4_y_i3", y, 4'h5);
    req = 4'b0000;
    step();
    check("t5_gnt", gnt, 4'b0000);
    check("t5_busy", busy, 0);
    check("t5_sel", {s1, s0}, 2'b11);
    step();
    check("t5_yv", y_valid, 0);
    check("t5_yhold", y, 4'h5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1111;
    for (int n = 0; n < 9; n++) step();
    check("t6_gnt", gnt, 4'b0100);
    reset = 1'b1;
    step();
    check("t6_rgnt", gnt, 4'b0000);
    check("t6_rsel", {s1, s0}, 2'b00);
    check("t6_rbusy", busy, 0);
    check("t6_ry", y, 0);
    check("t6_ryv", y_valid, 0);
    reset = 1'b0;
    step();
    check("t6_first", gnt, 4'b0001);
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(63) == 0;
      req = ($urandom_range(3) == 0) ? 4'($urandom) & 4'($urandom) : 4'($urandom);
      rand_data();
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
